vec_operand_loader: RTL

- Upstream feeder and result collector for the complex-double vector multiply-accumulate stage (vec_mult_acc).
- Accepts one complex element pair (a[k], b[k]) per beat on a valid/ready stream and packs mat_add_gen beats into the wide a/b operand buses.
- Sequences the MAC's valid/start/done/out_read_ack handshake, captures the dot-product result, and presents it on a valid/ready result port.
- One vector is in flight at a time.

---
 rtl/vec_operand_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vec_operand_loader.sv
// Packs mat_add_gen complex beats into the vec_mult_acc operand buses, sequences its handshake and holds the result on a valid/ready port.
// Optional in_last framing check: define VEC_LAST_CHECK_EN (without it err is tied 0 and vectors are framed by count).
module vec_operand_loader #(
  parameter int mat_add_gen = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [63:0]               in_a_real,
  input  logic [63:0]               in_a_imag,
  input  logic [63:0]               in_b_real,
  input  logic [63:0]               in_b_imag,
  input  logic                      in_last,
  output logic [64*mat_add_gen-1:0] a_real,
  output logic [64*mat_add_gen-1:0] a_imag,
  output logic [64*mat_add_gen-1:0] b_real,
  output logic [64*mat_add_gen-1:0] b_imag,
  output logic                      valid,
  output logic                      start,
  output logic                      out_read_ack,
  input  logic                      done,
  input  logic [63:0]               z_real,
  input  logic [63:0]               z_imag,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [63:0]               res_real,
  output logic [63:0]               res_imag,
  output logic                      err
);

  localparam int CW = $clog2(mat_add_gen) + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(mat_add_gen - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_ACK,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_cnt;
  logic                      r_kick2;
  logic [64*mat_add_gen-1:0] r_a_real;
  logic [64*mat_add_gen-1:0] r_a_imag;
  logic [64*mat_add_gen-1:0] r_b_real;
  logic [64*mat_add_gen-1:0] r_b_imag;
  logic [63:0]               r_res_real;
  logic [63:0]               r_res_imag;
  logic                      w_accept;
  logic                      w_last_slot;
  logic                      w_frame_err;
  logic                      w_vec_done;

  assign in_ready    = rst && (r_state == S_LOAD);
  assign w_accept    = in_valid && in_ready;
  assign w_last_slot = (r_cnt == LAST_SLOT);

`ifdef VEC_LAST_CHECK_EN
  logic r_err;

  // Early last (before final slot) and missing last (on final slot) both drop the partial vector.
  assign w_frame_err = w_accept && (in_last != w_last_slot);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_frame_err) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_last;

  assign w_unused_last = in_last;
  assign w_frame_err   = 1'b0;
  assign err           = 1'b0;
`endif

  assign w_vec_done = w_accept && w_last_slot && !w_frame_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    valid        = 1'b0;
    start        = 1'b0;
    out_read_ack = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_vec_done) begin
          w_next = S_KICK;
        end
      end
      S_KICK: begin
        valid = 1'b1;
        start = 1'b1;
        if (r_kick2) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        out_read_ack = 1'b1;
        w_next       = S_DRAIN;
      end
      S_DRAIN: begin
        // done lingers after the ack; leaving early would let WAIT see it as a new result
        if (!done) begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next = S_LOAD;
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_kick2    <= 1'b0;
      r_a_real   <= '0;
      r_a_imag   <= '0;
      r_b_real   <= '0;
      r_b_imag   <= '0;
      r_res_real <= '0;
      r_res_imag <= '0;
    end else begin
      if (w_accept) begin
        for (int k = 0; k < mat_add_gen; k++) begin
          if (r_cnt == CW'(k)) begin
            r_a_real[k*64 +: 64] <= in_a_real;
            r_a_imag[k*64 +: 64] <= in_a_imag;
            r_b_real[k*64 +: 64] <= in_b_real;
            r_b_imag[k*64 +: 64] <= in_b_imag;
          end
        end
        r_cnt <= (w_last_slot || w_frame_err) ? '0 : r_cnt + 1'b1;
      end
      r_kick2 <= (r_state == S_KICK) && !r_kick2;
      if ((r_state == S_WAIT) && done) begin
        r_res_real <= z_real;
        r_res_imag <= z_imag;
      end
    end
  end

  assign a_real   = r_a_real;
  assign a_imag   = r_a_imag;
  assign b_real   = r_b_real;
  assign b_imag   = r_b_imag;
  assign res_real = r_res_real;
  assign res_imag = r_res_imag;

endmodule
